// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register with ALU-control decode, hazard stall and branch flush.
// Define ID_EX_ILLEGAL_TRAP_EN to add the registered ex_illegal output.
package id_ex_alu_pkg;

    typedef enum logic [1:0] {
        OP_MEM   = 2'b00,
        OP_BR    = 2'b01,
        OP_RTYPE = 2'b10,
        OP_RSVD  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        SEL_AND = 3'b000,
        SEL_OR  = 3'b001,
        SEL_ADD = 3'b010,
        SEL_ILL = 3'b011,
        SEL_SUB = 3'b110,
        SEL_SLT = 3'b111
    } alu_sel_e;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

module id_ex_alu_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [1:0]            id_alu_op,
    input  logic [5:0]            id_funct,
    input  logic                  id_alu_src,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    output logic                  ex_valid,
    output logic [2:0]            ex_alu_signal,
    output logic [DATA_W-1:0]     ex_src_a,
    output logic [DATA_W-1:0]     ex_src_b,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
`ifdef ID_EX_ILLEGAL_TRAP_EN
    output logic                  ex_illegal,
`endif
    output logic                  ex_reg_write
);

    import id_ex_alu_pkg::*;

    typedef struct packed {
        logic                  valid;
        logic [2:0]            sel;
        logic [DATA_W-1:0]     src_a;
        logic [DATA_W-1:0]     src_b;
        logic [DATA_W-1:0]     rt_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  reg_write;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        logic                  illegal;
`endif
    } id_ex_t;

    alu_sel_e sel;
    logic     illegal;
    id_ex_t   nxt;
    id_ex_t   q;

    always_comb begin
        sel     = SEL_ILL;
        illegal = 1'b1;
        unique case (id_alu_op)
            OP_MEM: begin
                sel     = SEL_ADD;
                illegal = 1'b0;
            end
            OP_BR: begin
                sel     = SEL_SUB;
                illegal = 1'b0;
            end
            OP_RTYPE: begin
                illegal = 1'b0;
                unique case (id_funct)
                    FN_ADD:  sel = SEL_ADD;
                    FN_SUB:  sel = SEL_SUB;
                    FN_AND:  sel = SEL_AND;
                    FN_OR:   sel = SEL_OR;
                    FN_SLT:  sel = SEL_SLT;
                    default: begin
                        sel     = SEL_ILL;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_RSVD: begin
                sel     = SEL_ILL;
                illegal = 1'b1;
            end
        endcase
    end

    // An empty ID slot loads as an all-zero bubble.
    always_comb begin
        nxt = '0;
        if (id_valid) begin
            nxt.valid     = 1'b1;
            nxt.sel       = sel;
            nxt.src_a     = id_rs_data;
            nxt.src_b     = id_alu_src ? id_imm : id_rt_data;
            nxt.rt_data   = id_rt_data;
            nxt.rd_addr   = id_rd_addr;
            nxt.reg_write = id_reg_write & ~illegal;
`ifdef ID_EX_ILLEGAL_TRAP_EN
            nxt.illegal   = illegal;
`endif
        end
    end

    // Flush beats stall: the ID instruction is dropped, not held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= nxt;
        end
    end

    assign ex_valid      = q.valid;
    assign ex_alu_signal = q.sel;
    assign ex_src_a      = q.src_a;
    assign ex_src_b      = q.src_b;
    assign ex_rt_data    = q.rt_data;
    assign ex_rd_addr    = q.rd_addr;
    assign ex_reg_write  = q.reg_write;
`ifdef ID_EX_ILLEGAL_TRAP_EN
    assign ex_illegal    = q.illegal;
`endif

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Scoreboard bench for id_ex_alu_stage: directed vectors, queued expectations,
// monitor compares after every clock edge and on reset assertion.
module tb_id_ex_alu_stage;

    typedef struct packed {
        logic        v;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic        rw;
        logic        il;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [1:0]  id_alu_op = '0;
    logic [5:0]  id_funct = '0;
    logic        id_alu_src = 1'b0;
    logic [31:0] id_rs_data = '0;
    logic [31:0] id_rt_data = '0;
    logic [31:0] id_imm = '0;
    logic [4:0]  id_rd_addr = '0;
    logic        id_reg_write = 1'b0;
    logic        ex_valid;
    logic [2:0]  ex_alu_signal;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_il;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    done = 1'b0;

    localparam exp_t Z = '0;

    always #5 clk = ~clk;

    id_ex_alu_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .id_valid(id_valid),
        .id_alu_op(id_alu_op),
        .id_funct(id_funct),
        .id_alu_src(id_alu_src),
        .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data),
        .id_imm(id_imm),
        .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write),
        .ex_valid(ex_valid),
        .ex_alu_signal(ex_alu_signal),
        .ex_src_a(ex_src_a),
        .ex_src_b(ex_src_b),
        .ex_rt_data(ex_rt_data),
        .ex_rd_addr(ex_rd_addr),
`ifdef ID_EX_ILLEGAL_TRAP_EN
        .ex_illegal(ex_il),
`endif
        .ex_reg_write(ex_reg_write)
    );

`ifndef ID_EX_ILLEGAL_TRAP_EN
    assign ex_il = 1'b0;
`endif

    function automatic exp_t mk(input logic [2:0] sel, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] rt,
                                input logic [4:0] rd, input logic rw,
                                input logic il);
        exp_t e;
        e.v = 1'b1;
        e.sel = sel;
        e.a = a;
        e.b = b;
        e.rt = rt;
        e.rd = rd;
        e.rw = rw;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        e.il = il;
`else
        e.il = 1'b0 & il;
`endif
        return e;
    endfunction

    // Drive ID at a falling edge, queue the result expected after the next rise.
    task automatic drive(input string nm, input logic st, input logic fl,
                         input logic v, input logic [1:0] op,
                         input logic [5:0] fn, input logic src,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input logic rw, input exp_t e);
        stall = st;
        flush = fl;
        id_valid = v;
        id_alu_op = op;
        id_funct = fn;
        id_alu_src = src;
        id_rs_data = rs;
        id_rt_data = rt;
        id_imm = imm;
        id_rd_addr = rd;
        id_reg_write = rw;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {ex_valid, ex_alu_signal, ex_src_a, ex_src_b,
                       ex_rt_data, ex_rd_addr, ex_reg_write, ex_il};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s got v=%b sel=%b a=%h b=%h rt=%h rd=%0d rw=%b il=%b want v=%b sel=%b a=%h b=%h rt=%h rd=%0d rw=%b il=%b",
                             nm, got.v, got.sel, got.a, got.b, got.rt, got.rd,
                             got.rw, got.il, e.v, e.sel, e.a, e.b, e.rt, e.rd,
                             e.rw, e.il);
                end
            end
        end
    end

    initial begin : stim
        #1;
        exp_q.push_back(Z);
        name_q.push_back("reset_state");
        @(negedge clk);
        rst = 1'b0;

        drive("add_pre_rst", 0, 0, 1, 2'b10, 6'b100000, 0, 32'd5, 32'd7, 32'd0,
              5'd3, 1, mk(3'b010, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0));
        #2;
        exp_q.push_back(Z);
        name_q.push_back("async_reset");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        drive("add", 0, 0, 1, 2'b10, 6'b100000, 0, 32'd5, 32'd7, 32'd0,
              5'd3, 1, mk(3'b010, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0));
        drive("sub", 0, 0, 1, 2'b10, 6'b100010, 0, 32'd10, 32'd4, 32'd0,
              5'd4, 1, mk(3'b110, 32'd10, 32'd4, 32'd4, 5'd4, 1, 0));
        drive("and", 0, 0, 1, 2'b10, 6'b100100, 0, 32'd12, 32'd10, 32'd0,
              5'd5, 1, mk(3'b000, 32'd12, 32'd10, 32'd10, 5'd5, 1, 0));
        drive("or", 0, 0, 1, 2'b10, 6'b100101, 0, 32'd1, 32'd2, 32'd0,
              5'd6, 1, mk(3'b001, 32'd1, 32'd2, 32'd2, 5'd6, 1, 0));
        drive("slt", 0, 0, 1, 2'b10, 6'b101010, 0, 32'd3, 32'd9, 32'd0,
              5'd7, 1, mk(3'b111, 32'd3, 32'd9, 32'd9, 5'd7, 1, 0));
        drive("lw_imm", 0, 0, 1, 2'b00, 6'b000000, 1, 32'd100, 32'd55,
              32'hFFFF_FFFC, 5'd8, 1,
              mk(3'b010, 32'd100, 32'hFFFF_FFFC, 32'd55, 5'd8, 1, 0));
        drive("beq_funct_ign", 0, 0, 1, 2'b01, 6'b100100, 0, 32'd8, 32'd8,
              32'd0, 5'd0, 0, mk(3'b110, 32'd8, 32'd8, 32'd8, 5'd0, 0, 0));

        drive("stall_load_slt", 0, 0, 1, 2'b10, 6'b101010, 0, 32'd3, 32'd9,
              32'd0, 5'd4, 1, mk(3'b111, 32'd3, 32'd9, 32'd9, 5'd4, 1, 0));
        for (int i = 0; i < 3; i++)
            drive("stall_hold", 1, 0, 1, 2'b10, 6'b100101, 0, 32'd1, 32'd2,
                  32'd0, 5'd2, 1, mk(3'b111, 32'd3, 32'd9, 32'd9, 5'd4, 1, 0));
        drive("stall_release", 0, 0, 1, 2'b10, 6'b100101, 0, 32'd1, 32'd2,
              32'd0, 5'd2, 1, mk(3'b001, 32'd1, 32'd2, 32'd2, 5'd2, 1, 0));

        drive("flush_stall", 1, 1, 1, 2'b10, 6'b100000, 0, 32'd11, 32'd22,
              32'd0, 5'd9, 1, Z);
        drive("bubble_load", 0, 0, 0, 2'b10, 6'b100000, 1, 32'hDEAD_BEEF,
              32'h1234_5678, 32'hCAFE_F00D, 5'd31, 1, Z);
        drive("refill", 0, 0, 1, 2'b10, 6'b100010, 0, 32'd40, 32'd2, 32'd0,
              5'd1, 1, mk(3'b110, 32'd40, 32'd2, 32'd2, 5'd1, 1, 0));
        drive("flush_only", 0, 1, 1, 2'b10, 6'b100000, 0, 32'd7, 32'd7,
              32'd0, 5'd7, 1, Z);

        drive("illegal_funct", 0, 0, 1, 2'b10, 6'b000000, 0, 32'd6, 32'd7,
              32'd0, 5'd9, 1, mk(3'b011, 32'd6, 32'd7, 32'd7, 5'd9, 0, 1));
        drive("illegal_op11", 0, 0, 1, 2'b11, 6'b100000, 1, 32'd6, 32'd7,
              32'd15, 5'd9, 1, mk(3'b011, 32'd6, 32'd15, 32'd7, 5'd9, 0, 1));
        drive("legal_after_ill", 0, 0, 1, 2'b10, 6'b100000, 0, 32'd2, 32'd3,
              32'd0, 5'd10, 1, mk(3'b010, 32'd2, 32'd3, 32'd3, 5'd10, 1, 0));
        drive("idle", 0, 0, 0, 2'b00, 6'b000000, 0, 32'd0, 32'd0, 32'd0,
              5'd0, 0, Z);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (done);
            #5000;
        join_any
        if (!done) begin
            failures++;
            $display("FAIL timeout done=0 required=1");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
- ID/EX pipeline register for the pipelined CPU, combined with ALU-control decode.
- Each cycle it captures decoded operands and control from ID. It turns {alu_op, funct} into the 3-bit ALU select, chooses operand B (register or immediate), and presents a registered bundle to the EX-stage ALU and result mux.
- Supports hazard-unit stall (hold) and branch flush (bubble insertion).

Parameters:
- DATA_W, 32, operand/immediate width
- REG_ADDR_W, 5, register-file address width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold current EX contents (from hazard unit)
- flush  input  1  replace EX contents with a bubble (from branch unit)
- id_valid  input  1  ID holds a real instruction
- id_alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 reserved
- id_funct  input  6  instruction funct field
- id_alu_src  input  1  0: B = rt data, 1: B = immediate
- id_rs_data  input  DATA_W  rs read data
- id_rt_data  input  DATA_W  rt read data
- id_imm  input  DATA_W  sign-extended immediate
- id_rd_addr  input  REG_ADDR_W  destination register
- id_reg_write  input  1  instruction writes register file
- ex_valid  output  1  EX holds a real instruction
- ex_alu_signal  output  3  ALU select to EX result mux
- ex_src_a  output  DATA_W  ALU operand A
- ex_src_b  output  DATA_W  ALU operand B (already muxed)
- ex_rt_data  output  DATA_W  store data
- ex_rd_addr  output  REG_ADDR_W  destination register
- ex_reg_write  output  1  write-enable, qualified by valid

Behaviour:
- Reset: while rst=1, or on its assertion mid-cycle, all outputs go to 0 immediately (asynchronous). The first capture happens on the first rising edge after rst deasserts.
- All outputs are registered. Latency is 1 cycle from ID inputs to EX outputs. There is no combinational path from inputs to outputs.
- Per-edge priority is rst > flush > stall > load.
  - flush=1 (including with stall=1): bubble loaded. All outputs 0.
  - stall=1, flush=0: every output register holds its value.
  - Otherwise, load.
    - id_valid=0: load a bubble (all 0).
    - id_valid=1: ex_src_a=id_rs_data; ex_src_b = id_alu_src ? id_imm : id_rt_data; ex_rt_data=id_rt_data; ex_rd_addr=id_rd_addr; ex_valid=1; ex_alu_signal=decode.
- Decode:
  - alu_op 00 -> 010 (add)
  - alu_op 01 -> 110 (sub), funct ignored
  - alu_op 10, by funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
  - Any other funct with alu_op=10, and any alu_op=11, is illegal -> 011. The downstream mux yields 0 for 011.
- ex_reg_write = id_valid & id_reg_write & ~illegal. An illegal instruction never writes the register file but still occupies the slot (ex_valid=1).
- Simultaneous flush+stall: flush wins. The bubble is inserted and the ID instruction is dropped; the hazard unit is responsible for refetch.
- Stall held for N cycles: outputs identical for N cycles. On release, ID contents are loaded on the next edge.

Optional Feature:
- Macro ID_EX_ILLEGAL_TRAP_EN.
- When defined: adds output ex_illegal (1 bit), registered with the bundle. It is 1 when the loaded instruction decoded illegal, and follows the same reset/flush/stall rules.
- When undefined: the port is absent. Illegal instructions are silently converted to signal 011 with reg_write cleared.

Test Plan:
- Reset: assert rst mid-cycle with valid data loaded -> all outputs 0 before next edge. Release; load R-type add (alu_op=10, funct=100000, rs=5, rt=7) -> next cycle ex_alu_signal=010, src_a=5, src_b=7, ex_reg_write=1, ex_valid=1.
- Decode sweep: funct 100010/100100/100101/101010 with alu_op=10 -> 110/000/001/111. alu_op=00 with id_alu_src=1, imm=0xFFFFFFFC -> 010, src_b=0xFFFFFFFC. alu_op=01 funct=100100 -> 110.
- Stall: load slt (rs=3, rt=9), then stall=1 for 3 cycles while ID changes to or (rs=1, rt=2) -> EX shows 111/3/9 for 4 cycles total. Release -> 001/1/2.
- Flush: flush=1 together with stall=1 and a valid add in ID -> next cycle all outputs 0. Then id_valid=0 load -> outputs remain 0.
- Illegal: alu_op=10 funct=000000, id_reg_write=1 -> ex_alu_signal=011, ex_reg_write=0, ex_valid=1. alu_op=11 -> same. With ID_EX_ILLEGAL_TRAP_EN, ex_illegal=1; it returns to 0 on the next legal load.
